// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: instruction width, halt encoding and the loader state type.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LOAD  = 3'd1,
        LD_TERM  = 3'd2,
        LD_DONE  = 3'd3,
        LD_ERROR = 3'd4
    } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, appends a halt word, then releases the CPU.
// Optional running XOR of loaded words on `checksum` when PROG_LOADER_CHECKSUM_EN is defined.
//
// state    | meaning
// IDLE     | waiting for the first start after reset
// LOAD     | accepting instruction beats
// TERM     | writing the terminating NOP after the last word
// DONE     | program loaded, CPU released
// ERROR    | program exceeded IMEM_DEPTH
module prog_loader
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               s_valid,
    input  logic [INSTR_W-1:0] s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               overflow,
    output logic [ADDR_W:0]    word_count
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic [INSTR_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(IMEM_DEPTH);

    loader_state_e      state_q, state_d;
    logic [ADDR_W:0]    count_q, count_d, count_inc;
    logic               ovf_q, ovf_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               full, accept, restart;

    assign full      = (count_q == DEPTH);
    assign count_inc = count_q + (ADDR_W+1)'(1);
    assign accept    = (state_q == LD_LOAD) && s_valid && !full;
    assign restart   = start && ((state_q == LD_IDLE) || (state_q == LD_DONE) ||
                                 (state_q == LD_ERROR));

    always_ff @(posedge clk) begin
        if (reset) state_q <= LD_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: if (start) state_d = LD_LOAD;
            LD_LOAD: begin
                if (s_valid) begin
                    if (full)        state_d = LD_ERROR;
                    else if (s_last) state_d = (count_inc < DEPTH) ? LD_TERM : LD_DONE;
                end
            end
            LD_TERM: state_d = LD_DONE;
            default: state_d = LD_IDLE;
        endcase
    end

    // Both data beats and the halt word go through the same write register,
    // so the halt lands the cycle after the last data word.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (restart) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
        if (accept) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = s_data;
            count_d = count_inc;
        end
        if ((state_q == LD_LOAD) && s_valid && full) ovf_d = 1'b1;
        if (state_q == LD_TERM) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs read as reset values for the whole time reset is high, not just after the edge.
    always_comb begin
        s_ready    = (state_q == LD_LOAD) && !reset;
        done       = (state_q == LD_DONE) && !reset;
        cpu_reset  = !done;
        imem_we    = we_q && !reset;
        imem_addr  = reset ? '0 : addr_q;
        imem_wdata = reset ? '0 : wdata_q;
        overflow   = ovf_q && !reset;
        word_count = reset ? '0 : count_q;
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (restart) csum_d = '0;
        if (accept)  csum_d = csum_d ^ s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = reset ? '0 : csum_q;
`endif

endmodule
